// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline skid register: occupancy states and
// the layout of the control bundle carried alongside each beat.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam int ALUOP_W    = 3;
    localparam int CTRL_W_DEF = 10;

    // Bit offsets of each control field inside the bundle, ALUOp in the MSBs
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_REGDEST  = 6;
    localparam int CTRL_ALUOP    = 7;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle on both sides of a pipeline skid register.
interface pipe_skid_reg_if #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int REG_W     = 5,
    parameter int NUM_REGS  = 2,
    parameter int CTRL_W    = pipe_pkg::CTRL_W_DEF
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_WORDS*DATA_W-1:0]   in_data;
    logic [NUM_REGS*REG_W-1:0]     in_regs;
    logic [CTRL_W-1:0]             in_ctrl;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_WORDS*DATA_W-1:0]   out_data;
    logic [NUM_REGS*REG_W-1:0]     out_regs;
    logic [CTRL_W-1:0]             out_ctrl;

    // The stage itself
    modport slave (
        input  in_valid, in_data, in_regs, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_regs, out_ctrl
    );

    // The surrounding pipeline driving and consuming beats
    modport master (
        output in_valid, in_data, in_regs, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_regs, out_ctrl
    );
endinterface

// File: rtl/pipe_skid_reg_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline stage register (head + skid) with registered in_ready,
// flush and a saturating stall counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int REG_W     = 5,
    parameter int NUM_REGS  = 2,
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_skid_reg_if.slave   bus,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int DW = NUM_WORDS * DATA_W;
    localparam int RW = NUM_REGS * REG_W;

    localparam logic [1:0] ST_EMPTY = 2'(OCC_EMPTY);
    localparam logic [1:0] ST_ONE   = 2'(OCC_ONE);
    localparam logic [1:0] ST_TWO   = 2'(OCC_TWO);

    logic [1:0]        state_q,     state_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     head_data_q, head_data_d;
    logic [RW-1:0]     head_regs_q, head_regs_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic [DW-1:0]     skid_data_q, skid_data_d;
    logic [RW-1:0]     skid_regs_q, skid_regs_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic push;
    logic pop;

    assign push = bus.in_valid & in_ready_q;
    assign pop  = out_valid_q & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_regs_d = head_regs_q;
        head_ctrl_d = head_ctrl_q;
        skid_data_d = skid_data_q;
        skid_regs_d = skid_regs_q;
        skid_ctrl_d = skid_ctrl_q;

        // Flush drops everything held and anything arriving this cycle
        if (flush) begin
            state_d     = ST_EMPTY;
            head_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_data_d = bus.in_data;
                        head_regs_d = bus.in_regs;
                        head_ctrl_d = bus.in_ctrl;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push) begin
                        if (pop) begin
                            head_data_d = bus.in_data;
                            head_regs_d = bus.in_regs;
                            head_ctrl_d = bus.in_ctrl;
                        end else begin
                            skid_data_d = bus.in_data;
                            skid_regs_d = bus.in_regs;
                            skid_ctrl_d = bus.in_ctrl;
                            state_d     = ST_TWO;
                        end
                    end else if (pop) begin
                        head_ctrl_d = '0;
                        state_d     = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head_data_d = skid_data_q;
                        head_regs_d = skid_regs_q;
                        head_ctrl_d = skid_ctrl_q;
                        state_d     = ST_ONE;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    head_ctrl_d = '0;
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_data_q <= '0;
            head_regs_q <= '0;
            head_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_regs_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_data_q <= head_data_d;
            head_regs_q <= head_regs_d;
            head_ctrl_q <= head_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_regs_q <= skid_regs_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = head_data_q;
    assign bus.out_regs  = head_regs_q;
    assign bus.out_ctrl  = out_valid_q ? head_ctrl_q : '0;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid_q & ~bus.out_ready & ~flush),
        .count (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized bench for pipe_skid_reg against a queue-based model of a
// two-beat FIFO with flush and saturating stall counting.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    typedef struct {
        logic [127:0] data;
        logic [9:0]   regs;
        logic [9:0]   ctrl;
    } beat_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    pipe_skid_reg_if bus ();
    pipe_skid_reg_if bus4 ();

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_data   = bus.in_data;
    assign bus4.in_regs   = bus.in_regs;
    assign bus4.in_ctrl   = bus.in_ctrl;
    assign bus4.out_ready = bus.out_ready;

    pipe_skid_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt)
    );

    pipe_skid_reg #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus4.slave),
        .stall_cnt (stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t mdl_q[$];
    int    mdl_stall;
    int    mdl_stall4;
    int    compared_cnt;
    int    mismatch_cnt;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared_cnt++;
        if (obs !== exp) begin
            mismatch_cnt++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge
    task automatic applyStimulus(input logic rst_n, input logic fl, input logic iv,
                                 input logic ordy, input beat_t b);
        bit  m_push;
        bit  m_pop;
        bit  m_stalled;
        beat_t h;
        reset         = rst_n;
        flush         = fl;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.in_data   = b.data;
        bus.in_regs   = b.regs;
        bus.in_ctrl   = b.ctrl;

        m_push    = iv && (mdl_q.size() < 2);
        m_pop     = (mdl_q.size() > 0) && ordy;
        m_stalled = (mdl_q.size() > 0) && !ordy && !fl;
        if (!rst_n) begin
            mdl_q.delete();
            mdl_stall  = 0;
            mdl_stall4 = 0;
        end else begin
            if (fl) begin
                mdl_q.delete();
            end else begin
                if (m_pop)  void'(mdl_q.pop_front());
                if (m_push) mdl_q.push_back(b);
            end
            if (m_stalled) begin
                if (mdl_stall < 65535) mdl_stall++;
                if (mdl_stall4 < 15)   mdl_stall4++;
            end
        end

        @(posedge clk);
        #1;
        checkOutput("out_valid", 128'(bus.out_valid), 128'(mdl_q.size() > 0));
        checkOutput("in_ready", 128'(bus.in_ready), 128'(mdl_q.size() < 2));
        checkOutput("stall_cnt", 128'(stall_cnt), 128'(mdl_stall));
        checkOutput("stall_cnt4", 128'(stall_cnt4), 128'(mdl_stall4));
        if (mdl_q.size() > 0) begin
            h = mdl_q[0];
            checkOutput("out_ctrl", 128'(bus.out_ctrl), 128'(h.ctrl));
            checkOutput("out_data", bus.out_data, h.data);
            checkOutput("out_regs", 128'(bus.out_regs), 128'(h.regs));
        end else begin
            checkOutput("out_ctrl_bubble", 128'(bus.out_ctrl), 128'd0);
        end
        if (!rst_n) begin
            checkOutput("rst_out_data", bus.out_data, 128'd0);
            checkOutput("rst_out_regs", 128'(bus.out_regs), 128'd0);
        end
    endtask

    function automatic beat_t randBeat();
        beat_t b;
        b.data = {$urandom, $urandom, $urandom, $urandom};
        b.regs = 10'($urandom);
        b.ctrl = 10'($urandom);
        return b;
    endfunction

    function automatic beat_t mkBeat(input logic [127:0] d, input logic [9:0] c);
        beat_t b;
        b.data = d;
        b.regs = 10'(d[9:0]);
        b.ctrl = c;
        return b;
    endfunction

    beat_t nb;

    initial begin
        compared_cnt = 0;
        mismatch_cnt = 0;
        mdl_stall    = 0;
        mdl_stall4   = 0;
        nb = mkBeat(128'd0, 10'd0);

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, nb);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, nb);

        $display("[TB] single beat latency");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, mkBeat(128'h4, 10'h155));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, nb);

        $display("[TB] fill to TWO under stall then drain");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, mkBeat(128'hA, 10'h3FF));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, mkBeat(128'hB, 10'h001));
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, randBeat());
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, nb);

        $display("[TB] flush from TWO with input present");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, randBeat());
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, randBeat());
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, mkBeat(128'hDEAD, 10'h2AA));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, nb);

        $display("[TB] push and pop together in ONE");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, randBeat());
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, randBeat());
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, nb);

        $display("[TB] long stall for saturation");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, randBeat());
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, nb);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, nb);

        $display("[TB] reset while TWO with push and flush");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, randBeat());
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, randBeat());
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, randBeat());
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, mkBeat(128'h1234_5678, 10'h0F0));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, nb);

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            logic r_rst, r_fl, r_iv, r_ordy;
            r_rst  = ($urandom_range(0, 99) != 0);
            r_fl   = ($urandom_range(0, 31) == 0);
            r_iv   = ($urandom_range(0, 9) < 7);
            r_ordy = ((i / 50) % 4 == 3) ? 1'b0 : ($urandom_range(0, 9) < 6);
            applyStimulus(r_rst, r_fl, r_iv, r_ordy, randBeat());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of each data word.
REQ-002 SHALL have parameter NUM_WORDS, default 4: data words per beat (pc_4, reg1, reg2, sign_extend).
REQ-003 SHALL have parameter REG_W, default 5: width of each register-index field.
REQ-004 SHALL have parameter NUM_REGS, default 2: register-index fields per beat (rt, rd).
REQ-005 SHALL have parameter CTRL_W, default 10: control-bundle width (7 single-bit controls + 3-bit ALUOp).
REQ-006 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-007 clk  input  1  sole clock; all state updates on the rising edge.
REQ-008 reset  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-009 flush  input  1  kills all held beats and the beat presented in the same cycle.
REQ-010 in_valid  input  1  upstream beat present.
REQ-011 in_ready  output  1  stage can accept a beat; driven from a register.
REQ-012 in_data  input  NUM_WORDS*DATA_W  packed data words, word 0 in the LSBs.
REQ-013 in_regs  input  NUM_REGS*REG_W  packed register indices.
REQ-014 in_ctrl  input  CTRL_W  control bundle.
REQ-015 out_valid  output  1  beat held at the head.
REQ-016 out_ready  input  1  downstream accepts the head beat.
REQ-017 out_data, out_regs, out_ctrl  output  same widths as inputs  head beat.
REQ-018 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-019 SHALL hold up to two beats: head (main) and skid; occupancy states EMPTY, ONE, TWO.
REQ-020 Push occurs when in_valid and in_ready; pop occurs when out_valid and out_ready.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO; it is registered and depends on no input combinationally.
REQ-022 Transitions: EMPTY+push->ONE; ONE+push only->TWO; ONE+pop only->EMPTY; ONE+push+pop->ONE (new beat becomes head); TWO+pop->ONE (skid moves to head); no push or pop->state unchanged.
REQ-023 Latency SHALL be one cycle: a beat pushed into EMPTY appears at the outputs on the next cycle.
REQ-024 Beats SHALL leave in push order; no beat is duplicated or dropped except by flush or reset.
REQ-025 While out_valid=1 and out_ready=0, out_data/out_regs/out_ctrl SHALL stay stable.
REQ-026 When out_valid=0, out_ctrl SHALL be all-zero (bubble); out_data and out_regs are don't-care.
REQ-027 flush=1 SHALL force the next state to EMPTY, discard any same-cycle push, and suppress the same-cycle pop (the downstream must treat the head as killed).
REQ-028 flush SHALL take priority over push, pop and stall counting.
REQ-029 stall_cnt SHALL increment by 1 in each cycle where out_valid=1, out_ready=0, and flush=0; it SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-030 stall_cnt SHALL be unaffected by flush; only reset clears it.

Reset
REQ-031 When reset=0 at a rising edge, the next state SHALL be: state EMPTY, out_valid=0, in_ready=1, out_data=0, out_regs=0, out_ctrl=0, skid entry=0, stall_cnt=0.
REQ-032 Reset SHALL override flush, push and pop in the same cycle; a reset during TWO SHALL drop both beats.
REQ-033 in_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-034 Package pipe_pkg SHALL hold the occupancy-state enum, the ALUOp width (3) and the CTRL_W default, plus field-offset constants for the control bundle (RegWrite, MemToReg, MemRead, MemWrite, Branch, ALUSrc, RegDest, ALUOp).
REQ-035 The saturating counter SHALL be a sub-module sat_counter (parameter CNT_W; inputs clk, reset, inc; output count).
REQ-036 The ID/EX instance SHALL be built from this module with default parameters; other stage registers override the parameters.

Verification
REQ-037 Reset, then push in_data word0=0x00000004 with out_ready=1 -> out_valid=1 one cycle later with out_data word0=0x00000004; in_ready stays 1.
REQ-038 out_ready=0, push beats A (ctrl=0x3FF) then B (ctrl=0x001) -> state TWO, in_ready=0; head=A stable; stall_cnt=1 after the first stalled cycle and counts up each cycle; raise out_ready -> A then B exit in order on consecutive cycles.
REQ-039 State TWO, assert flush together with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the flushed input never appears at the outputs.
REQ-040 State ONE with push and pop in the same cycle for 8 consecutive cycles -> one beat out per cycle, state remains ONE, in_ready is never 0.
REQ-041 CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
REQ-042 State TWO, drive reset=0 for one edge while push=1 and flush=1 -> outputs match REQ-031 values; the first push after reset is delivered correctly.
